// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle control FSM for the RV32I-subset core.
// Sequences fetch/decode/execute/memory/writeback over one shared memory port.
// Ports: clk, rst (sync, active-high); IR fields opcode/funct3/funct7b5;
//   alu_zero, mem_ready in; memory request (mem_req/mem_we/iord), IR/PC/regfile
//   write enables, pc_sel, immsel, ALU selects, wb_sel, sticky illegal out.
// Optional: define CTRL_PERF_CNT_EN to add the CNT_W-bit retired counter port.
module riscv_mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       immsel,
    output logic             alu_a,
    output logic [1:0]       alu_b,
    output logic [2:0]       alu_op,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
`ifdef CTRL_PERF_CNT_EN
    output logic             illegal,
    output logic [CNT_W-1:0] retired
`else
    output logic             illegal
`endif
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_illegal;
    logic [3:0] w_alu_r;
    logic [3:0] w_alu_i;

    // Returns {supported, alu_op}; sub only applies to funct3=000.
    function automatic logic [3:0] f_alu(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  f_alu = {1'b1, (sub ? 3'b001 : 3'b000)};
            3'b111:  f_alu = 4'b1010;
            3'b110:  f_alu = 4'b1011;
            3'b010:  f_alu = 4'b1100;
            default: f_alu = 4'b0000;
        endcase
    endfunction

    assign w_alu_r = f_alu(funct3, funct7b5);
    assign w_alu_i = f_alu(funct3, 1'b0);

    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        iord    = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 2'b00;
        immsel  = 2'b00;
        alu_a   = 1'b0;
        alu_b   = 2'b00;
        alu_op  = 3'b000;
        reg_we  = 1'b0;
        wb_sel  = 2'b00;
        illegal = r_illegal;
        w_next  = r_state;
        unique case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes PC+imm(B) for a possible branch
                alu_a  = 1'b1;
                alu_b  = 2'b01;
                immsel = 2'b10;
                case (opcode)
                    OP_R:         w_next = S_EXEC_R;
                    OP_I:         w_next = S_EXEC_I;
                    OP_LD, OP_ST: w_next = S_MEM_ADDR;
                    OP_BR:        w_next = S_BRANCH;
                    OP_JAL:       w_next = S_JAL;
                    OP_JALR:      w_next = S_JALR;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_op = w_alu_r[2:0];
                w_next = w_alu_r[3] ? S_WB_ALU : S_TRAP;
            end
            S_EXEC_I: begin
                alu_b  = 2'b01;
                alu_op = w_alu_i[2:0];
                w_next = w_alu_i[3] ? S_WB_ALU : S_TRAP;
            end
            S_MEM_ADDR: begin
                // opcode[5] separates store (0100011) from load (0000011)
                alu_b  = 2'b01;
                immsel = opcode[5] ? 2'b01 : 2'b00;
                if (funct3 != 3'b010)
                    w_next = S_TRAP;
                else
                    w_next = opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready)
                    w_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                immsel  = 2'b01;
                if (mem_ready)
                    w_next = S_FETCH;
            end
            S_WB_ALU: begin
                reg_we = 1'b1;
                w_next = S_FETCH;
            end
            S_WB_MEM: begin
                reg_we = 1'b1;
                wb_sel = 2'b01;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_op = 3'b001;
                immsel = 2'b10;
                pc_sel = 2'b01;
                case (funct3)
                    3'b000: begin
                        pc_we  = alu_zero;
                        w_next = S_FETCH;
                    end
                    3'b001: begin
                        pc_we  = !alu_zero;
                        w_next = S_FETCH;
                    end
                    default: w_next = S_TRAP;
                endcase
            end
            S_JAL: begin
                immsel = 2'b11;
                reg_we = 1'b1;
                wb_sel = 2'b10;
                pc_we  = 1'b1;
                pc_sel = 2'b01;
                w_next = S_FETCH;
            end
            S_JALR: begin
                alu_b  = 2'b01;
                reg_we = 1'b1;
                wb_sel = 2'b10;
                pc_we  = 1'b1;
                pc_sel = 2'b10;
                w_next = S_FETCH;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            iord    = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            pc_sel  = 2'b00;
            immsel  = 2'b00;
            alu_a   = 1'b0;
            alu_b   = 2'b00;
            alu_op  = 3'b000;
            reg_we  = 1'b0;
            wb_sel  = 2'b00;
            illegal = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP)
                r_illegal <= 1'b1;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_retired;

    // Every return to FETCH marks one completed instruction.
    always_ff @(posedge clk) begin
        if (rst)
            r_retired <= '0;
        else if (r_state != S_FETCH && w_next == S_FETCH)
            r_retired <= r_retired + 1'b1;
    end

    assign retired = rst ? '0 : r_retired;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: table-driven cycle traces plus directed corner sequences
// for the multi-cycle control FSM.
module tb_riscv_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [1:0] immsel;
    logic       alu_a;
    logic [1:0] alu_b;
    logic [2:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       illegal;
`ifdef CTRL_PERF_CNT_EN
    logic [3:0] retired;
`endif

    int n_chk;
    int n_fail;

`ifdef CTRL_PERF_CNT_EN
    riscv_mc_ctrl #(.CNT_W(4)) dut (
`else
    riscv_mc_ctrl dut (
`endif
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .immsel(immsel), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel),
`ifdef CTRL_PERF_CNT_EN
        .illegal(illegal), .retired(retired)
`else
        .illegal(illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] w_out;
    assign w_out = {mem_req, mem_we, iord, ir_we, pc_we, pc_sel, immsel,
                    alu_a, alu_b, alu_op, reg_we, wb_sel, illegal};

    function automatic logic [18:0] mk(
        input logic req, we, io, irw, pcw,
        input logic [1:0] ps, im,
        input logic a,
        input logic [1:0] b,
        input logic [2:0] op,
        input logic rw,
        input logic [1:0] wb,
        input logic il);
        return {req, we, io, irw, pcw, ps, im, a, b, op, rw, wb, il};
    endfunction

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    vec_t tv[$];

    logic [18:0] X_F, X_FS, X_D, X_WBA, X_MAL, X_MAS, X_MRD, X_MWR;
    logic [18:0] X_WBM, X_JAL, X_JALR, X_TRP, X_Z;

    function automatic logic [18:0] x_ei(input logic [2:0] op);
        return mk(0,0,0,0,0,2'b00,2'b00,0,2'b01,op,0,2'b00,0);
    endfunction

    function automatic logic [18:0] x_er(input logic [2:0] op);
        return mk(0,0,0,0,0,2'b00,2'b00,0,2'b00,op,0,2'b00,0);
    endfunction

    function automatic logic [18:0] x_br(input logic pcw);
        return mk(0,0,0,0,pcw,2'b01,2'b10,0,2'b00,3'b001,0,2'b00,0);
    endfunction

    task automatic add(input logic [6:0] o, input logic [2:0] f,
                       input logic f7, z, r, input logic [18:0] e);
        vec_t v;
        v.opc = o; v.f3 = f; v.f7 = f7; v.z = z; v.rdy = r; v.exp = e;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [18:0] a,
                       input logic [18:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, a, e);
        end
    endtask

    task automatic cyc(input string nm, input logic [6:0] o,
                       input logic [2:0] f, input logic f7, z, r,
                       input logic [18:0] e);
        opcode = o; funct3 = f; funct7b5 = f7; alu_zero = z; mem_ready = r;
        #1;
        chk(nm, w_out, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;
    localparam logic [6:0] JR = 7'b1100111;
    localparam logic [6:0] BAD = 7'h7F;

    initial begin
        n_chk = 0;
        n_fail = 0;
        X_F   = mk(1,0,0,1,1,2'b00,2'b00,0,2'b00,3'b000,0,2'b00,0);
        X_FS  = mk(1,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,0,2'b00,0);
        X_D   = mk(0,0,0,0,0,2'b00,2'b10,1,2'b01,3'b000,0,2'b00,0);
        X_WBA = mk(0,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,1,2'b00,0);
        X_MAL = mk(0,0,0,0,0,2'b00,2'b00,0,2'b01,3'b000,0,2'b00,0);
        X_MAS = mk(0,0,0,0,0,2'b00,2'b01,0,2'b01,3'b000,0,2'b00,0);
        X_MRD = mk(1,0,1,0,0,2'b00,2'b00,0,2'b00,3'b000,0,2'b00,0);
        X_MWR = mk(1,1,1,0,0,2'b00,2'b01,0,2'b00,3'b000,0,2'b00,0);
        X_WBM = mk(0,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,1,2'b01,0);
        X_JAL = mk(0,0,0,0,1,2'b01,2'b11,0,2'b00,3'b000,1,2'b10,0);
        X_JALR= mk(0,0,0,0,1,2'b10,2'b00,0,2'b01,3'b000,1,2'b10,0);
        X_TRP = mk(0,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,0,2'b00,1);
        X_Z   = '0;

        // addi x1,x0,5: F,D,EXEC_I,WB_ALU
        add(I,3'b000,0,0,1,X_F);  add(I,3'b000,0,0,1,X_D);
        add(I,3'b000,0,0,1,x_ei(3'b000)); add(I,3'b000,0,0,1,X_WBA);
        // add / sub
        add(R,3'b000,0,0,1,X_F);  add(R,3'b000,0,0,0,X_D);
        add(R,3'b000,0,0,1,x_er(3'b000)); add(R,3'b000,0,0,0,X_WBA);
        add(R,3'b000,1,0,1,X_F);  add(R,3'b000,1,0,1,X_D);
        add(R,3'b000,1,0,1,x_er(3'b001)); add(R,3'b000,1,0,1,X_WBA);
        // andi, or, slti (funct7b5 ignored for I)
        add(I,3'b111,0,0,1,X_F);  add(I,3'b111,0,0,1,X_D);
        add(I,3'b111,0,0,1,x_ei(3'b010)); add(I,3'b111,0,0,1,X_WBA);
        add(R,3'b110,0,0,1,X_F);  add(R,3'b110,0,0,1,X_D);
        add(R,3'b110,0,0,1,x_er(3'b011)); add(R,3'b110,0,0,1,X_WBA);
        add(I,3'b010,1,0,1,X_F);  add(I,3'b010,1,0,1,X_D);
        add(I,3'b010,1,0,1,x_ei(3'b100)); add(I,3'b010,1,0,1,X_WBA);
        // lw with one fetch stall
        add(LD,3'b010,0,0,0,X_FS); add(LD,3'b010,0,0,1,X_F);
        add(LD,3'b010,0,0,1,X_D);  add(LD,3'b010,0,0,1,X_MAL);
        add(LD,3'b010,0,0,1,X_MRD); add(LD,3'b010,0,0,1,X_WBM);
        // sw
        add(ST,3'b010,0,0,1,X_F);  add(ST,3'b010,0,0,1,X_D);
        add(ST,3'b010,0,0,1,X_MAS); add(ST,3'b010,0,0,1,X_MWR);
        // beq taken / not taken, bne not taken / taken
        add(BR,3'b000,0,1,1,X_F);  add(BR,3'b000,0,1,1,X_D);
        add(BR,3'b000,0,1,1,x_br(1));
        add(BR,3'b000,0,0,1,X_F);  add(BR,3'b000,0,0,1,X_D);
        add(BR,3'b000,0,0,1,x_br(0));
        add(BR,3'b001,0,1,1,X_F);  add(BR,3'b001,0,1,1,X_D);
        add(BR,3'b001,0,1,1,x_br(0));
        add(BR,3'b001,0,0,1,X_F);  add(BR,3'b001,0,0,1,X_D);
        add(BR,3'b001,0,0,1,x_br(1));
        // jal, jalr
        add(JL,3'b000,0,0,1,X_F);  add(JL,3'b000,0,0,1,X_D);
        add(JL,3'b000,0,0,1,X_JAL);
        add(JR,3'b000,0,0,1,X_F);  add(JR,3'b000,0,0,1,X_D);
        add(JR,3'b000,0,0,1,X_JALR);
        add(I,3'b000,0,0,1,X_F);

        rst = 1'b1;
        opcode = '0; funct3 = '0; funct7b5 = 1'b0;
        alu_zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_outputs", w_out, X_Z);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tv[i])
            cyc($sformatf("trace[%0d]", i), tv[i].opc, tv[i].f3,
                tv[i].f7, tv[i].z, tv[i].rdy, tv[i].exp);

        // store held while memory stalls
        do_reset();
        cyc("sw_f", ST,3'b010,0,0,1,X_F);
        cyc("sw_d", ST,3'b010,0,0,1,X_D);
        cyc("sw_ma", ST,3'b010,0,0,1,X_MAS);
        for (int k = 0; k < 3; k++)
            cyc($sformatf("sw_wait%0d", k), ST,3'b010,0,0,0,X_MWR);
        cyc("sw_done", ST,3'b010,0,0,1,X_MWR);
        cyc("sw_next_f", ST,3'b010,0,0,0,X_FS);

        // illegal opcode: trap is sticky until reset
        do_reset();
        cyc("bad_f", BAD,3'b000,0,0,1,X_F);
        cyc("bad_d", BAD,3'b000,0,0,1,X_D);
        for (int k = 0; k < 10; k++)
            cyc($sformatf("trap%0d", k), BAD,3'b000,0,0,k[0],X_TRP);
        rst = 1'b1;
        cyc("trap_rst", BAD,3'b000,0,0,1,X_Z);
        rst = 1'b0;
        cyc("trap_exit_f", I,3'b000,0,0,1,X_F);

        // unsupported R funct3 (sll)
        do_reset();
        cyc("sll_f", R,3'b001,0,0,1,X_F);
        cyc("sll_d", R,3'b001,0,0,1,X_D);
        cyc("sll_ex", R,3'b001,0,0,1,x_er(3'b000));
        cyc("sll_trap", R,3'b001,0,0,1,X_TRP);

        // lb (funct3 000) traps without a memory access
        do_reset();
        cyc("lb_f", LD,3'b000,0,0,1,X_F);
        cyc("lb_d", LD,3'b000,0,0,1,X_D);
        cyc("lb_ma", LD,3'b000,0,0,1,X_MAL);
        cyc("lb_trap", LD,3'b000,0,0,1,X_TRP);

        // unsupported branch funct3 (blt)
        do_reset();
        cyc("blt_f", BR,3'b100,0,1,1,X_F);
        cyc("blt_d", BR,3'b100,0,1,1,X_D);
        cyc("blt_br", BR,3'b100,0,1,1,x_br(0));
        cyc("blt_trap", BR,3'b100,0,1,1,X_TRP);

        // reset in the middle of a load access
        do_reset();
        cyc("rl_f", LD,3'b010,0,0,1,X_F);
        cyc("rl_d", LD,3'b010,0,0,1,X_D);
        cyc("rl_ma", LD,3'b010,0,0,1,X_MAL);
        cyc("rl_wait", LD,3'b010,0,0,0,X_MRD);
        rst = 1'b1;
        cyc("rl_rst", LD,3'b010,0,0,0,X_Z);
        rst = 1'b0;
        cyc("rl_after_f", LD,3'b010,0,0,1,X_F);

`ifdef CTRL_PERF_CNT_EN
        do_reset();
        for (int n = 0; n < 17; n++) begin
            cyc("cnt_f", I,3'b000,0,0,1,X_F);
            cyc("cnt_d", I,3'b000,0,0,1,X_D);
            cyc("cnt_ex", I,3'b000,0,0,1,x_ei(3'b000));
            cyc("cnt_wb", I,3'b000,0,0,1,X_WBA);
        end
        n_chk++;
        if (retired !== 4'd1) begin
            n_fail++;
            $display("FAIL retired_wrap: got %0d want 1", retired);
        end
        cyc("cl_f", LD,3'b010,0,0,1,X_F);
        cyc("cl_d", LD,3'b010,0,0,1,X_D);
        cyc("cl_ma", LD,3'b010,0,0,1,X_MAL);
        cyc("cl_wait", LD,3'b010,0,0,0,X_MRD);
        rst = 1'b1;
        cyc("cl_rst", LD,3'b010,0,0,0,X_Z);
        rst = 1'b0;
        #1;
        n_chk++;
        if (retired !== 4'd0) begin
            n_fail++;
            $display("FAIL retired_rst: got %0d want 0", retired);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
